// File: rtl/cpu5_pkg.sv
// Shared types and default widths for the 5-bit CPU: sequencer state, flag bundle and
// the instruction-field layout {opcode, operand}.
package cpu5_pkg;

    localparam int DEF_OPC_W   = 4;
    localparam int DEF_OPR_W   = 5;
    localparam int DEF_PC_W    = 5;
    localparam int DEF_RST_PC  = 0;
    localparam int DEF_INSTR_W = DEF_OPC_W + DEF_OPR_W;

    // Field positions within an instruction word at the default widths.
    localparam int DEF_OPR_LSB = 0;
    localparam int DEF_OPC_LSB = DEF_OPR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC
    } state_t;

    typedef struct packed {
        logic zf;
        logic sf;
        logic cf;
    } flags_t;

endpackage

// File: rtl/cpu5_flag_reg.sv
// Three-bit ZF/SF/CF register with write enable and asynchronous active-low reset.
module cpu5_flag_reg
    import cpu5_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   we,
    input  flags_t d,
    output flags_t q
);

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer of the 5-bit CPU: owns PC, IR and flags, fetches over req/ack.
// Optional single-step input is enabled with the SINGLE_STEP_EN macro.
module fetch_sequencer
    import cpu5_pkg::*;
#(
    parameter int             OPC_W  = DEF_OPC_W,
    parameter int             OPR_W  = DEF_OPR_W,
    parameter int             PC_W   = DEF_PC_W,
    parameter logic [PC_W-1:0] RST_PC = PC_W'(DEF_RST_PC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
`ifdef SINGLE_STEP_EN
    input  logic                   step,
`endif
    output logic                   imem_req,
    output logic [PC_W-1:0]        imem_addr,
    input  logic                   imem_ack,
    input  logic [OPC_W+OPR_W-1:0] imem_rdata,
    output logic [OPC_W-1:0]       opcode,
    output logic [OPR_W-1:0]       operand,
    output logic                   ir_valid,
    output logic                   zf_q,
    output logic                   sf_q,
    output logic                   cf_q,
    input  logic                   alu_zf,
    input  logic                   alu_sf,
    input  logic                   alu_cf,
    input  logic                   flag_we,
    input  logic                   jmp_sel,
    output logic [PC_W-1:0]        pc
);

    localparam int INSTR_W = OPC_W + OPR_W;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q;
    logic [INSTR_W-1:0]  ir_q;
    logic                req_q;
    logic                valid_q;
    logic                start;
    logic [PC_W-1:0]     jmp_target;
    flags_t              alu_flags;
    flags_t              flags_q;

`ifdef SINGLE_STEP_EN
    // A step pulse launches one instruction; the EXEC exit still consults run.
    assign start = run | step;
`else
    assign start = run;
`endif

    assign jmp_target = PC_W'(ir_q[OPR_W-1:0]);
    assign alu_flags  = {alu_zf, alu_sf, alu_cf};

    // NOTE: defaults are assigned first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (imem_ack) state_d = S_EXEC;
            S_EXEC:  state_d = run ? S_FETCH : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // req/valid are registered from the next state so they line up with the state register;
    // the async reset drops an in-flight request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RST_PC;
            ir_q    <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == S_FETCH);
            valid_q <= (state_d == S_EXEC);
            if (state_q == S_FETCH && imem_ack) begin
                ir_q <= imem_rdata;
            end
            if (state_q == S_EXEC) begin
                pc_q <= jmp_sel ? jmp_target : pc_q + PC_W'(1);
            end
        end
    end

    // Flags written at the close of EXEC, so a jump always sees an earlier instruction's flags.
    cpu5_flag_reg u_flag_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (flag_we && (state_q == S_EXEC)),
        .d     (alu_flags),
        .q     (flags_q)
    );

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign opcode    = ir_q[INSTR_W-1:OPR_W];
    assign operand   = ir_q[OPR_W-1:0];
    assign ir_valid  = valid_q;
    assign zf_q      = flags_q.zf;
    assign sf_q      = flags_q.sf;
    assign cf_q      = flags_q.cf;

endmodule
